// File: rtl/mem_stage.sv
// mem_stage -- MEM stage of a 5-stage MIPS pipeline.
//
// Takes the EX-stage ALU result as an effective address, runs one access on
// a req/ack data-memory port, aligns/extends load data, builds store byte
// enables and replicated write data, and hands a write-back packet to WB.
// EX is stalled (in_ready low) while an access is outstanding.
//
// Optional build macro: MEM_TIMEOUT_EN adds a dm_ack watchdog and the
// exc_bus output. Without it, WAIT persists until dm_ack arrives.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   EX handshake: an instruction is taken on a rising
//                       edge where in_valid && in_ready (in_ready = IDLE)
//   alu_c, store_data   address / pass-through data, store source value
//   mem_op, rd_in, wen_in  operation code, destination, write enable
//   dm_*                data-memory port; dm_req held with all dm_* stable
//                       until the single-cycle dm_ack, dm_rdata valid then
//   out_*               WB packet, qualified by the one-cycle out_valid
//   exc_misalign, exc_addr  misaligned-access pulse and faulting address
//   exc_bus             watchdog timeout pulse (MEM_TIMEOUT_EN only)
module mem_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_c,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_op,
  input  logic [4:0]  rd_in,
  input  logic        wen_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        exc_misalign,
  output logic [31:0] exc_addr
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        exc_bus
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_wen_q, out_wen_d;
  logic        exc_mis_q, exc_mis_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exc_bus_q, exc_bus_d;
`endif

  // Decode of the incoming operation.
  logic        is_load, is_store, is_mem, misalign;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  // Load alignment of the returned word using the latched op/offset.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  always_comb begin
    is_load   = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    is_store  = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    is_mem    = is_load || is_store;
    misalign  = 1'b0;
    be_new    = 4'b1111;
    wdata_new = 32'd0;
    case (mem_op)
      OP_LH, OP_LHU: misalign = alu_c[0];
      OP_LW:         misalign = (alu_c[1:0] != 2'b00);
      OP_SB: begin
        be_new    = 4'b0001 << alu_c[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      OP_SH: begin
        misalign  = alu_c[0];
        be_new    = 4'b0011 << alu_c[1:0];
        wdata_new = {2{store_data[15:0]}};
      end
      OP_SW: begin
        misalign  = (alu_c[1:0] != 2'b00);
        wdata_new = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    sel_byte = dm_rdata[7:0];
      2'd1:    sel_byte = dm_rdata[15:8];
      2'd2:    sel_byte = dm_rdata[23:16];
      default: sel_byte = dm_rdata[31:24];
    endcase
    sel_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'd0, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'd0, sel_half};
      OP_LW:   load_data = dm_rdata;
      default: load_data = 32'd0;  // stores retire with zero data
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_be_d     = dm_be_q;
    dm_wdata_d  = dm_wdata_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    exc_mis_d   = 1'b0;
    exc_addr_d  = exc_addr_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    exc_bus_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_c;
            out_rd_d    = rd_in;
            out_wen_d   = wen_in;
          end else if (misalign) begin
            exc_mis_d   = 1'b1;
            exc_addr_d  = alu_c;
            out_valid_d = 1'b1;
            out_wen_d   = 1'b0;
          end else begin
            state_d    = S_WAIT;
            dm_req_d   = 1'b1;
            dm_we_d    = is_store;
            dm_addr_d  = {alu_c[31:2], 2'b00};
            dm_be_d    = be_new;
            dm_wdata_d = wdata_new;
            op_d       = mem_op;
            off_d      = alu_c[1:0];
            rd_d       = rd_in;
            wen_d      = wen_in & ~is_store;
`ifdef MEM_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end
        end
      end
      default: begin  // S_WAIT
        if (dm_ack) begin
          state_d     = S_IDLE;
          dm_req_d    = 1'b0;
          dm_we_d     = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = load_data;
          out_rd_d    = rd_q;
          out_wen_d   = wen_q;
        end
`ifdef MEM_TIMEOUT_EN
        // An ack in the final counted cycle takes priority over the timeout.
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d     = S_IDLE;
          dm_req_d    = 1'b0;
          dm_we_d     = 1'b0;
          exc_bus_d   = 1'b1;
          exc_addr_d  = {dm_addr_q[31:2], off_q};
          out_valid_d = 1'b1;
          out_wen_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_be_q     <= 4'd0;
      dm_wdata_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_rd_q    <= 5'd0;
      out_wen_q   <= 1'b0;
      exc_mis_q   <= 1'b0;
      exc_addr_q  <= 32'd0;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
      wen_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      exc_bus_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_be_q     <= dm_be_d;
      dm_wdata_q  <= dm_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      exc_mis_q   <= exc_mis_d;
      exc_addr_q  <= exc_addr_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      exc_bus_q   <= exc_bus_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_be        = dm_be_q;
  assign dm_wdata     = dm_wdata_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_rd       = out_rd_q;
  assign out_wen      = out_wen_q;
  assign exc_misalign = exc_mis_q;
  assign exc_addr     = exc_addr_q;
`ifdef MEM_TIMEOUT_EN
  assign exc_bus      = exc_bus_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_c;
  logic [31:0] store_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_in;
  logic        wen_in;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        exc_misalign;
  logic [31:0] exc_addr;
`ifdef MEM_TIMEOUT_EN
  logic        exc_bus;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_c(alu_c), .store_data(store_data), .mem_op(mem_op),
    .rd_in(rd_in), .wen_in(wen_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_wen(out_wen), .exc_misalign(exc_misalign), .exc_addr(exc_addr)
`ifdef MEM_TIMEOUT_EN
    , .exc_bus(exc_bus)
`endif
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; returns just after the accept edge.
  task automatic drive_op(input logic [3:0] op, input logic [31:0] c,
                          input logic [31:0] sd, input logic [4:0] rd,
                          input logic wen);
    in_valid   = 1'b1;
    mem_op     = op;
    alu_c      = c;
    store_data = sd;
    rd_in      = rd;
    wen_in     = wen;
    tick();
    in_valid = 1'b0;
  endtask

  // Raise dm_ack with data for one cycle; returns just after the ack edge.
  task automatic drive_ack(input logic [31:0] rdata);
    dm_ack   = 1'b1;
    dm_rdata = rdata;
    tick();
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({dm_req, dm_we, out_valid, out_wen, exc_misalign} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 00000",
               {dm_req, dm_we, out_valid, out_wen, exc_misalign});
    end
    tests_run++;
    if ({dm_addr, dm_be, dm_wdata, out_data, out_rd, exc_addr} !== 137'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: addr=%h be=%b wdata=%h data=%h rd=%0d exc_addr=%h required all 0",
               dm_addr, dm_be, dm_wdata, out_data, out_rd, exc_addr);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    drive_op(4'd5, 32'h0000_0100, 32'h0, 5'd8, 1'b1);
    tests_run++;
    if ({dm_req, dm_we, dm_addr, dm_be} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
      tests_failed++;
      $display("FAIL lw_req: req=%b we=%b addr=%h be=%b required 1 0 00000100 1111",
               dm_req, dm_we, dm_addr, dm_be);
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({in_ready, out_valid, dm_req} !== 3'b001) begin
        tests_failed++;
        $display("FAIL lw_stall%0d: in_ready=%b out_valid=%b dm_req=%b required 0 0 1",
                 i, in_ready, out_valid, dm_req);
      end
      tick();
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_stall_ack_cycle: in_ready=%b required 0", in_ready);
    end
    drive_ack(32'hDEAD_BEEF);
    tests_run++;
    if ({out_valid, out_data, out_rd, out_wen, dm_req, in_ready} !==
        {1'b1, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL lw_retire: valid=%b data=%h rd=%0d wen=%b req=%b ready=%b required 1 deadbeef 8 1 0 1",
               out_valid, out_data, out_rd, out_wen, dm_req, in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_pulse: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_load_extend();
    logic [3:0]  ops   [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] rdat  [5] = '{32'h8011_2233, 32'h8011_2233, 32'h8000_1234,
                               32'h8000_1234, 32'h8011_2233};
    logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000,
                               32'h0000_8000, 32'h0000_0033};
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], addrs[i], 32'h0, 5'd3, 1'b1);
      tests_run++;
      if ({dm_addr, dm_be} !== {32'h100, 4'b1111}) begin
        tests_failed++;
        $display("FAIL load%0d_port: addr=%h be=%b required 00000100 1111", i, dm_addr, dm_be);
      end
      drive_ack(rdat[i]);
      tests_run++;
      if ({out_valid, out_data} !== {1'b1, exps[i]}) begin
        tests_failed++;
        $display("FAIL load%0d_data: valid=%b data=%h required 1 %h", i, out_valid, out_data, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    drive_op(4'd7, 32'h102, 32'h1234_ABCD, 5'd9, 1'b1);
    tests_run++;
    if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata} !==
        {1'b1, 1'b1, 32'h100, 4'b1100, 32'hABCD_ABCD}) begin
      tests_failed++;
      $display("FAIL sh_port: req=%b we=%b addr=%h be=%b wdata=%h required 1 1 00000100 1100 abcdabcd",
               dm_req, dm_we, dm_addr, dm_be, dm_wdata);
    end
    tick();
    tests_run++;
    if ({dm_req, dm_we, dm_be, dm_wdata} !== {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD}) begin
      tests_failed++;
      $display("FAIL sh_hold: req=%b we=%b be=%b wdata=%h required 1 1 1100 abcdabcd",
               dm_req, dm_we, dm_be, dm_wdata);
    end
    drive_ack(32'h5555_5555);
    tests_run++;
    if ({out_valid, out_wen, out_data, dm_req} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL sh_retire: valid=%b wen=%b data=%h req=%b required 1 0 00000000 0",
               out_valid, out_wen, out_data, dm_req);
    end
    tick();
    drive_op(4'd6, 32'h201, 32'h0000_00EF, 5'd1, 1'b1);
    tests_run++;
    if ({dm_we, dm_addr, dm_be, dm_wdata} !== {1'b1, 32'h200, 4'b0010, 32'hEFEF_EFEF}) begin
      tests_failed++;
      $display("FAIL sb_port: we=%b addr=%h be=%b wdata=%h required 1 00000200 0010 efefefef",
               dm_we, dm_addr, dm_be, dm_wdata);
    end
    drive_ack(32'h0);
    tick();
  endtask

  task automatic test_misalign();
    drive_op(4'd5, 32'h101, 32'h0, 5'd4, 1'b1);
    tests_run++;
    if ({exc_misalign, exc_addr, out_valid, out_wen, dm_req, in_ready} !==
        {1'b1, 32'h101, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL misalign: exc=%b addr=%h valid=%b wen=%b req=%b ready=%b required 1 00000101 1 0 0 1",
               exc_misalign, exc_addr, out_valid, out_wen, dm_req, in_ready);
    end
    tick();
    tests_run++;
    if ({exc_misalign, out_valid, dm_req} !== 3'b000) begin
      tests_failed++;
      $display("FAIL misalign_after: exc=%b valid=%b req=%b required 0 0 0",
               exc_misalign, out_valid, dm_req);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      mem_op   = (i == 3) ? 4'd9 : 4'd0;  // 9 decodes as NONE
      alu_c    = 32'(i);
      rd_in    = 5'(i + 10);
      wen_in   = 1'b1;
      tick();
      tests_run++;
      if ({out_valid, out_data, out_rd, out_wen, dm_req} !==
          {1'b1, 32'(i), 5'(i + 10), 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL b2b%0d: valid=%b data=%h rd=%0d wen=%b req=%b required 1 %h %0d 1 0",
                 i, out_valid, out_data, out_rd, out_wen, dm_req, 32'(i), i + 10);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    drive_op(4'd5, 32'h300, 32'h0, 5'd5, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if ({dm_req, in_ready, out_valid} !== 3'b010) begin
      tests_failed++;
      $display("FAIL rst_mid: req=%b ready=%b valid=%b required 0 1 0", dm_req, in_ready, out_valid);
    end
    drive_ack(32'h1234_5678);
    tests_run++;
    if ({out_valid, dm_req, in_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL late_ack: valid=%b req=%b ready=%b required 0 0 1", out_valid, dm_req, in_ready);
    end
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    drive_op(4'd5, 32'h104, 32'h0, 5'd6, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (exc_bus === 1'b1) begin
        n = i;
        break;
      end
    end
    tests_run++;
    if (n != 16) begin
      tests_failed++;
      $display("FAIL timeout_latency: exc_bus after %0d cycles (0 = never) required 16", n);
    end
    tests_run++;
    if ({dm_req, out_valid, out_wen, exc_addr} !== {1'b0, 1'b1, 1'b0, 32'h104}) begin
      tests_failed++;
      $display("FAIL timeout_pkt: req=%b valid=%b wen=%b addr=%h required 0 1 0 00000104",
               dm_req, out_valid, out_wen, exc_addr);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    alu_c      = 32'h0;
    store_data = 32'h0;
    mem_op     = 4'd0;
    rd_in      = 5'd0;
    wen_in     = 1'b0;
    dm_ack     = 1'b0;
    dm_rdata   = 32'h0;
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_misalign();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX-stage ALU.
- Uses the ALU result C as the effective address for loads and stores.
- Drives a req/ack data-memory port, aligns and extends load data, and generates byte enables for stores.
- Stalls EX while an access is outstanding, then hands a write-back packet to WB.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles to wait for dm_ack; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  EX presents an instruction this cycle.
- in_ready  out  1  stage can accept; low stalls EX.
- alu_c  in  32  ALU result, used as address or as pass-through data.
- store_data  in  32  rt value for stores.
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
- rd_in  in  5  destination register.
- wen_in  in  1  register write enable from decode.
- dm_req  out  1  memory request, held until ack.
- dm_we  out  1  1 = store.
- dm_addr  out  32  {alu_c[31:2], 2'b00}.
- dm_be  out  4  byte enables; bit i = byte lane i, little-endian.
- dm_wdata  out  32  store data replicated across lanes.
- dm_ack  in  1  one-cycle completion pulse.
- dm_rdata  in  32  read word, valid in the dm_ack cycle.
- out_valid  out  1  one-cycle pulse per retired instruction.
- out_data  out  32  load result, or alu_c for NONE.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable to WB.
- exc_misalign  out  1  one-cycle pulse on a misaligned access.
- exc_addr  out  32  faulting address.
- exc_bus  out  1  timeout pulse; only exists with MEM_TIMEOUT_EN, see below.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - in_ready=1.
  - dm_req, dm_we, out_valid, out_wen, exc_misalign, exc_bus = 0.
  - dm_addr, dm_be, dm_wdata, out_data, out_rd, exc_addr = 0.
  - Reset wins over every other event, including mid-access: dm_req drops after that edge and the pending access is discarded with no output.
- FSM states: IDLE and WAIT. in_ready = (state==IDLE).
- IDLE, in_valid=1, op NONE:
  - Next edge: out_valid=1, out_data=alu_c, out_rd=rd_in, out_wen=wen_in.
  - Latency is 1 cycle. Stay in IDLE, so back-to-back NONE ops sustain one per cycle.
- IDLE, in_valid=1, misaligned memory op:
  - Misaligned means LH/LHU/SH with alu_c[0]=1, or LW/SW with alu_c[1:0]!=0.
  - Next edge: exc_misalign=1, exc_addr=alu_c, out_valid=1, out_wen=0. No dm_req. Stay in IDLE.
- IDLE, in_valid=1, aligned memory op:
  - Next edge: dm_req=1, dm_we set for stores, dm_addr latched, dm_be/dm_wdata latched. Go to WAIT.
  - The op, byte offset, rd_in and wen_in are latched.
  - Stores force the latched wen to 0.
- Byte enables:
  - SB: 4'b0001 << alu_c[1:0].
  - SH: 4'b0011 << alu_c[1:0].
  - SW and loads: 4'b1111.
- Write data:
  - SB: {4{store_data[7:0]}}.
  - SH: {2{store_data[15:0]}}.
  - SW: store_data.
- WAIT state:
  - dm_req and all dm_* outputs hold stable until dm_ack.
  - On the edge where dm_ack=1: dm_req=0, out_valid=1, out_rd/out_wen from the latched values, go to IDLE.
  - out_data on that edge:
    - LB/LBU: selected byte, sign- or zero-extended.
    - LH/LHU: selected halfword, sign- or zero-extended.
    - LW: dm_rdata.
    - Stores: 0.
  - Minimum memory-op occupancy is 2 cycles.
  - A new instruction can be accepted on the first cycle back in IDLE, never in the ack cycle itself.
- dm_ack seen in IDLE is ignored.
- exc_misalign, exc_bus and out_valid are single-cycle pulses. They are cleared on the next edge unless re-triggered.
- Pulse-only signals: out_data, out_rd and exc_addr hold their last value. WB qualifies everything with out_valid. There is no downstream backpressure.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Adds output exc_bus and a wait counter.
  - The counter clears on entering WAIT and increments each WAIT cycle without dm_ack.
  - If the counter reaches TIMEOUT_CYC without dm_ack: next edge dm_req=0, exc_bus=1, exc_addr=latched address, out_valid=1, out_wen=0, go to IDLE.
  - If dm_ack arrives in the same cycle the counter reaches TIMEOUT_CYC, the ack wins and there is no exc_bus.
- Undefined:
  - No counter and no exc_bus port.
  - WAIT persists indefinitely until dm_ack.

Test Plan:
- LW at alu_c=0x00000100, dm_ack 3 cycles after dm_req with dm_rdata=0xDEADBEEF, rd_in=8, wen_in=1:
  - dm_addr=0x100, dm_be=4'b1111.
  - in_ready low until the ack edge.
  - One out_valid pulse with out_data=0xDEADBEEF, out_rd=8, out_wen=1.
- LB at 0x103 with dm_rdata=0x80112233 → out_data=0xFFFFFF80. Same access as LBU → 0x00000080.
- LH at 0x102 with dm_rdata=0x80001234 → out_data=0xFFFF8000.
- SH at 0x102 with store_data=0x1234ABCD:
  - dm_we=1, dm_be=4'b1100, dm_wdata=0xABCDABCD.
  - On ack, out_valid=1 with out_wen=0.
- LW at 0x101:
  - Next cycle exc_misalign=1, exc_addr=0x101, out_wen=0.
  - dm_req never asserts, and in_ready stays 1.
- Five back-to-back NONE ops (alu_c = 1..5): five consecutive out_valid pulses carrying 1..5.
- rst_n=0 while in WAIT:
  - After the edge, dm_req=0, state IDLE, no out_valid.
  - A late dm_ack is ignored.
- MEM_TIMEOUT_EN with TIMEOUT_CYC=16: LW with no ack → dm_req drops and exc_bus pulses 16 cycles after entering WAIT.
